// File: rtl/sprite_motion_ctrl.sv
// Player sprite controller: frame-paced erase -> update -> redraw sequencer with saturating
// motion, terrain blocking, gravity, bubble push, background scroll, win and overrun flags.
module sprite_motion_ctrl #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int S_W       = 9,
  parameter int X_INIT    = 80,
  parameter int Y_INIT    = 80,
  parameter int S_INIT    = 280,
  parameter int X_MAX     = 149,
  parameter int Y_MIN     = 40,
  parameter int Y_MAX     = 103,
  parameter int STEP      = 2,
  parameter int GRAV      = 1,
  parameter int TICK_DIV  = 833333,
  parameter int FRAME_DIV = 16,
  parameter int WIN_THR   = 2
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [3:0]     kb,
  input  logic [3:0]     blk,
  input  logic           push_up,
  input  logic           push_down,
  input  logic [1:0]     push_speed,
  input  logic           draw_done,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [S_W-1:0] scroll_y,
  output logic           plot,
  output logic           erase,
  output logic           frame_tick,
  output logic           anim,
  output logic           win,
  output logic           overrun
);

  localparam int XE   = X_W + 1;
  localparam int YE   = Y_W + 1;
  localparam int SE   = S_W + 1;
  localparam int TC_W = $clog2(TICK_DIV + 1);
  localparam int FC_W = $clog2(FRAME_DIV + 1);

  typedef enum logic [2:0] {INIT, WAIT, ERASE, UPDATE, DRAW, DONE} state_t;

  state_t          state_reg;
  logic [TC_W-1:0] tick_cnt_reg;
  logic [FC_W-1:0] frame_cnt_reg;
  logic [X_W-1:0]  pos_x_reg, x_next;
  logic [Y_W-1:0]  pos_y_reg, y_next;
  logic [S_W-1:0]  scroll_reg, s_next;
  logic            plot_reg, erase_reg, frame_tick_reg, anim_reg, win_reg, overrun_reg;
  logic            pending_reg;
  logic            tick_wrap, frame_wrap;
  logic            key_u, key_d, key_r, key_l;

  // Saturating helpers: arithmetic is one bit wider than the operand so nothing wraps.
  function automatic logic [Y_W-1:0] y_add(input logic [Y_W-1:0] y, input logic [YE-1:0] d);
    logic [YE-1:0] s;
    s = {1'b0, y} + d;
    return (s > YE'(Y_MAX)) ? Y_W'(Y_MAX) : s[Y_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] y_sub(input logic [Y_W-1:0] y, input logic [YE-1:0] d);
    return ({1'b0, y} >= d + YE'(Y_MIN)) ? y - d[Y_W-1:0] : Y_W'(Y_MIN);
  endfunction

  function automatic logic [S_W-1:0] s_sub(input logic [S_W-1:0] s, input logic [SE-1:0] d);
    return ({1'b0, s} >= d) ? s - d[S_W-1:0] : '0;
  endfunction

  assign key_u      = ~kb[3];
  assign key_d      = ~kb[2];
  assign key_r      = ~kb[1];
  assign key_l      = ~kb[0];
  assign tick_wrap  = (tick_cnt_reg == TC_W'(TICK_DIV - 1));
  assign frame_wrap = (frame_cnt_reg == FC_W'(FRAME_DIV - 1));

  always_comb begin
    y_next = pos_y_reg;
    s_next = scroll_reg;
    if (push_down && pos_y_reg < Y_W'(Y_MAX)) begin
      y_next = y_add(pos_y_reg, YE'(push_speed));
    end else if (push_up) begin
      if (pos_y_reg > Y_W'(Y_MIN)) y_next = y_sub(pos_y_reg, YE'(push_speed));
      else                          s_next = s_sub(scroll_reg, SE'(push_speed));
    end else if (kb == 4'b1111 && pos_y_reg < Y_W'(Y_MAX) && !blk[2]) begin
      y_next = y_add(pos_y_reg, YE'(GRAV));
    end else if (key_u && !key_d && !blk[3]) begin
      // Near the top line "up" scrolls the world instead of moving the sprite.
      if (pos_y_reg > Y_W'(Y_MIN)) y_next = y_sub(pos_y_reg, YE'(STEP));
      else                          s_next = s_sub(scroll_reg, SE'(STEP));
    end else if (key_d && !key_u && !blk[2]) begin
      y_next = y_add(pos_y_reg, YE'(STEP));
    end
  end

  always_comb begin
    x_next = pos_x_reg;
    if (key_r && !key_l && !blk[1]) begin
      x_next = ({1'b0, pos_x_reg} + XE'(STEP) > XE'(X_MAX)) ? X_W'(X_MAX) : pos_x_reg + X_W'(STEP);
    end else if (key_l && !key_r && !blk[0]) begin
      x_next = ({1'b0, pos_x_reg} >= XE'(STEP)) ? pos_x_reg - X_W'(STEP) : '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= INIT;
      tick_cnt_reg   <= '0;
      frame_cnt_reg  <= '0;
      pos_x_reg      <= X_W'(X_INIT);
      pos_y_reg      <= Y_W'(Y_INIT);
      scroll_reg     <= S_W'(S_INIT);
      plot_reg       <= 1'b0;
      erase_reg      <= 1'b0;
      frame_tick_reg <= 1'b0;
      anim_reg       <= 1'b0;
      win_reg        <= 1'b0;
      overrun_reg    <= 1'b0;
      pending_reg    <= 1'b0;
    end else begin
      tick_cnt_reg   <= tick_wrap ? '0 : tick_cnt_reg + TC_W'(1);
      if (tick_wrap) frame_cnt_reg <= frame_wrap ? '0 : frame_cnt_reg + FC_W'(1);
      frame_tick_reg <= tick_wrap && frame_wrap;
      if (tick_wrap && frame_wrap) anim_reg <= ~anim_reg;
      if (frame_tick_reg) pending_reg <= 1'b1;
      if (frame_tick_reg && pending_reg) overrun_reg <= 1'b1;

      case (state_reg)
        INIT: begin
          if (plot_reg && draw_done) begin
            state_reg <= WAIT;
            plot_reg  <= 1'b0;
          end else begin
            plot_reg  <= 1'b1;
          end
          erase_reg <= 1'b0;
        end
        WAIT: begin
          if (pending_reg || frame_tick_reg) begin
            state_reg   <= ERASE;
            plot_reg    <= 1'b1;
            erase_reg   <= 1'b1;
            pending_reg <= 1'b0;
          end
        end
        ERASE: begin
          if (plot_reg && draw_done) begin
            state_reg <= UPDATE;
            plot_reg  <= 1'b0;
            erase_reg <= 1'b0;
          end
        end
        UPDATE: begin
          pos_x_reg  <= x_next;
          pos_y_reg  <= y_next;
          scroll_reg <= s_next;
          if (s_next <= S_W'(WIN_THR)) win_reg <= 1'b1;
          state_reg  <= DRAW;
          plot_reg   <= 1'b1;
          erase_reg  <= 1'b0;
        end
        DRAW: begin
          if (plot_reg && draw_done) begin
            state_reg <= win_reg ? DONE : WAIT;
            plot_reg  <= 1'b0;
          end
        end
        DONE: begin
          plot_reg  <= 1'b0;
          erase_reg <= 1'b0;
        end
        default: begin
          state_reg <= INIT;
          plot_reg  <= 1'b0;
          erase_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pos_x      = pos_x_reg;
  assign pos_y      = pos_y_reg;
  assign scroll_y   = scroll_reg;
  assign plot       = plot_reg;
  assign erase      = erase_reg;
  assign frame_tick = frame_tick_reg;
  assign anim       = anim_reg;
  assign win        = win_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: frame-level reference model, a vector table,
// randomized frames and hand sequences for bounds, win/DONE, overrun and async reset.
module tb_sprite_motion_ctrl;
  localparam int X_INIT = 80, Y_INIT = 80, S_INIT = 280;
  localparam int X_MAX = 149, Y_MIN = 40, Y_MAX = 103, STEP = 2, GRAV = 1, WIN_THR = 2;

  logic       clock, resetn;
  logic [3:0] kb, blk;
  logic       push_up, push_down, draw_done;
  logic [1:0] push_speed;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [8:0] scroll_y;
  logic       plot, erase, frame_tick, anim, win, overrun;

  int total = 0, bad = 0, nframe = 0;
  int mx, my, ms;
  bit mwin, saw_plot;

  sprite_motion_ctrl #(.TICK_DIV(4), .FRAME_DIV(2)) dut (
    .clock(clock), .resetn(resetn), .kb(kb), .blk(blk), .push_up(push_up),
    .push_down(push_down), .push_speed(push_speed), .draw_done(draw_done),
    .pos_x(pos_x), .pos_y(pos_y), .scroll_y(scroll_y), .plot(plot), .erase(erase),
    .frame_tick(frame_tick), .anim(anim), .win(win), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] kb;
    logic [3:0] blk;
    logic       pu;
    logic       pd;
    logic [1:0] ps;
    int         ex;
    int         ey;
    int         es;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  // Frame-level model: one application of the motion rules per frame, frozen after a win.
  task automatic model_step(input logic [3:0] k, input logic [3:0] b, input logic pu,
                            input logic pd, input int ps);
    bit up, dn, rt, lf;
    if (mwin) return;
    up = !k[3]; dn = !k[2]; rt = !k[1]; lf = !k[0];
    if (pd && my < Y_MAX) my = imin(my + ps, Y_MAX);
    else if (pu) begin
      if (my > Y_MIN) my = imax(my - ps, Y_MIN); else ms = imax(ms - ps, 0);
    end
    else if (k == 4'hF && my < Y_MAX && !b[2]) my = imin(my + GRAV, Y_MAX);
    else if (up && !dn && !b[3]) begin
      if (my > Y_MIN) my = imax(my - STEP, Y_MIN); else ms = imax(ms - STEP, 0);
    end
    else if (dn && !up && !b[2]) my = imin(my + STEP, Y_MAX);
    if (rt && !lf && !b[1]) mx = imin(mx + STEP, X_MAX);
    else if (lf && !rt && !b[0]) mx = imax(mx - STEP, 0);
    if (ms <= WIN_THR) mwin = 1;
  endtask

  task automatic model_reset();
    mx = X_INIT; my = Y_INIT; ms = S_INIT; mwin = 0;
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (frame_tick) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL frame_tick_timeout: got no tick expected tick within 40 cycles");
    end
  endtask

  task automatic do_frame(input logic [3:0] k, input logic [3:0] b, input logic pu,
                          input logic pd, input logic [1:0] ps);
    kb = k; blk = b; push_up = pu; push_down = pd; push_speed = ps;
    wait_tick();
    saw_plot = 0;
    repeat (4) begin
      @(negedge clock);
      if (plot) saw_plot = 1;
    end
    model_step(k, b, pu, pd, int'(ps));
    nframe++;
    $display("frame %0d kb=%b blk=%b pu=%0b pd=%0b ps=%0d -> x=%0d y=%0d s=%0d win=%0b",
             nframe, k, b, pu, pd, ps, pos_x, pos_y, scroll_y, win);
    chk("model_x", int'(pos_x), mx);
    chk("model_y", int'(pos_y), my);
    chk("model_s", int'(scroll_y), ms);
    chk("model_win", int'(win), int'(mwin));
  endtask

  task automatic start_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    model_reset();
    resetn = 1'b1;
  endtask

  initial begin
    int tick_at;
    tbl[0]  = '{4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 80, 82, 280};
    tbl[1]  = '{4'hB, 4'h0, 1'b0, 1'b0, 2'd0, 80, 84, 280};
    tbl[2]  = '{4'hD, 4'h0, 1'b0, 1'b0, 2'd0, 82, 84, 280};
    tbl[3]  = '{4'hD, 4'h2, 1'b0, 1'b0, 2'd0, 82, 84, 280};
    tbl[4]  = '{4'hE, 4'h0, 1'b0, 1'b0, 2'd0, 80, 84, 280};
    tbl[5]  = '{4'h3, 4'h0, 1'b0, 1'b0, 2'd0, 80, 84, 280};
    tbl[6]  = '{4'h7, 4'h0, 1'b0, 1'b0, 2'd0, 80, 82, 280};
    tbl[7]  = '{4'h7, 4'h8, 1'b0, 1'b0, 2'd0, 80, 82, 280};
    tbl[8]  = '{4'hF, 4'h4, 1'b0, 1'b0, 2'd0, 80, 82, 280};
    tbl[9]  = '{4'hF, 4'h0, 1'b0, 1'b1, 2'd3, 80, 85, 280};
    tbl[10] = '{4'hF, 4'h0, 1'b1, 1'b0, 2'd3, 80, 82, 280};
    tbl[11] = '{4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 80, 84, 280};
    tbl[12] = '{4'hC, 4'h0, 1'b0, 1'b0, 2'd0, 80, 84, 280};
    tbl[13] = '{4'h6, 4'h0, 1'b0, 1'b0, 2'd0, 78, 82, 280};
    tbl[14] = '{4'hF, 4'h0, 1'b0, 1'b1, 2'd0, 78, 82, 280};

    // Reset values, INIT handshake, first tick timing and one gravity frame.
    kb = 4'hF; blk = 4'h0; push_up = 0; push_down = 0; push_speed = 0; draw_done = 0;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pos_x", int'(pos_x), 80);
    chk("rst_pos_y", int'(pos_y), 80);
    chk("rst_scroll", int'(scroll_y), 280);
    chk("rst_plot", int'(plot), 0);
    chk("rst_erase", int'(erase), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    chk("rst_anim", int'(anim), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_overrun", int'(overrun), 0);
    model_reset();
    resetn = 1'b1;
    tick_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) begin chk("init_plot", int'(plot), 1); chk("init_erase", int'(erase), 0); end
      if (i == 2) begin chk("init_plot_hold", int'(plot), 1); draw_done = 1; end
      if (i == 3) chk("wait_plot", int'(plot), 0);
      if (frame_tick) begin tick_at = i; break; end
    end
    chk("first_tick_cycle", tick_at, 8);
    chk("anim_toggle", int'(anim), 1);
    @(negedge clock);
    chk("tick_one_cycle", int'(frame_tick), 0);
    chk("erase_plot", int'(plot), 1);
    chk("erase_erase", int'(erase), 1);
    @(negedge clock);
    chk("update_plot", int'(plot), 0);
    @(negedge clock);
    chk("draw_plot", int'(plot), 1);
    chk("draw_erase", int'(erase), 0);
    @(negedge clock);
    chk("back_wait_plot", int'(plot), 0);
    model_step(4'hF, 4'h0, 1'b0, 1'b0, 0);
    chk("gravity_y", int'(pos_y), 81);
    chk("gravity_model_y", int'(pos_y), my);
    $display("frame 0 kb=1111 gravity -> x=%0d y=%0d s=%0d", pos_x, pos_y, scroll_y);

    for (int i = 0; i < 15; i++) begin
      do_frame(tbl[i].kb, tbl[i].blk, tbl[i].pu, tbl[i].pd, tbl[i].ps);
      chk($sformatf("tbl%0d_x", i), int'(pos_x), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), int'(pos_y), tbl[i].ey);
      chk($sformatf("tbl%0d_s", i), int'(scroll_y), tbl[i].es);
    end

    for (int i = 0; i < 60; i++) begin
      logic [3:0] rk, rb;
      logic rpu, rpd;
      rk  = 4'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rpu = ($urandom_range(0, 7) == 0);
      rpd = ($urandom_range(0, 7) == 0);
      do_frame(rk, rb, rpu, rpd, 2'($urandom));
    end

    // Saturation at Y_MAX, push at the floor, top-line scroll, X_MAX, win and DONE.
    start_reset();
    for (int i = 0; i < 12; i++) do_frame(4'hB, 4'h0, 0, 0, 0);
    chk("ymax_sat", int'(pos_y), 103);
    do_frame(4'hF, 4'h0, 0, 0, 0);
    chk("ymax_gravity_hold", int'(pos_y), 103);
    do_frame(4'hF, 4'h0, 1, 1, 2'd1);
    chk("ymax_push_up", int'(pos_y), 102);
    for (int i = 0; i < 31; i++) do_frame(4'h7, 4'h0, 0, 0, 0);
    chk("ymin_reach", int'(pos_y), 40);
    do_frame(4'h7, 4'h0, 0, 0, 0);
    chk("scroll_step_s", int'(scroll_y), 278);
    chk("scroll_step_y", int'(pos_y), 40);
    do_frame(4'h3, 4'h0, 0, 0, 0);
    chk("ud_hold_s", int'(scroll_y), 278);
    for (int i = 0; i < 34; i++) do_frame(4'hD, 4'h0, 0, 0, 0);
    chk("x_148", int'(pos_x), 148);
    do_frame(4'hD, 4'h2, 0, 0, 0);
    chk("x_blocked", int'(pos_x), 148);
    do_frame(4'hD, 4'h0, 0, 0, 0);
    chk("x_max", int'(pos_x), 149);
    do_frame(4'hD, 4'h0, 0, 0, 0);
    chk("x_max_hold", int'(pos_x), 149);
    for (int i = 0; i < 137; i++) do_frame(4'h7, 4'h0, 0, 0, 0);
    chk("scroll_4", int'(scroll_y), 4);
    chk("no_win_yet", int'(win), 0);
    do_frame(4'hF, 4'h0, 1, 0, 2'd3);
    chk("push_scroll", int'(scroll_y), 1);
    chk("win_set", int'(win), 1);
    for (int i = 0; i < 2; i++) begin
      do_frame(4'h7, 4'h0, 0, 0, 0);
      chk("done_scroll", int'(scroll_y), 1);
      chk("done_no_plot", int'(saw_plot), 0);
      chk("done_win", int'(win), 1);
    end

    // Overrun while stuck in ERASE, single UPDATE on release, then reset mid-ERASE.
    draw_done = 1; kb = 4'hF; blk = 4'h0; push_up = 0; push_down = 0; push_speed = 0;
    start_reset();
    wait_tick();
    draw_done = 0;
    wait_tick();
    chk("ovr_not_yet", int'(overrun), 0);
    chk("ovr_still_erase", int'(erase), 1);
    wait_tick();
    @(negedge clock);
    chk("ovr_set", int'(overrun), 1);
    draw_done = 1;
    @(negedge clock);
    chk("ovr_update_plot", int'(plot), 0);
    @(negedge clock);
    chk("ovr_draw_plot", int'(plot), 1);
    chk("ovr_one_update", int'(pos_y), 81);
    @(negedge clock);
    chk("ovr_wait_plot", int'(plot), 0);
    draw_done = 0;
    @(negedge clock);
    chk("ovr_reenter_erase", int'(erase), 1);
    chk("ovr_reenter_plot", int'(plot), 1);
    chk("ovr_y_once", int'(pos_y), 81);
    $display("overrun sequence: overrun=%0b y=%0d", overrun, pos_y);
    resetn = 1'b0;
    #1;
    chk("arst_pos_y", int'(pos_y), 80);
    chk("arst_plot", int'(plot), 0);
    chk("arst_erase", int'(erase), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_anim", int'(anim), 0);
    chk("arst_scroll", int'(scroll_y), 280);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
